// File: rtl/fetch_pkg.sv
// Shared widths, reset address and fetch buffer entry type for the fetch stage.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'd0;
  localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decode delivery channel: head instruction and its address.
interface fetch_if;
  import fetch_pkg::*;

  // Transfer happens on a rising edge where out_valid && out_ready. While
  // out_valid is high and out_ready low, out_instr/out_pc are held stable.
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; push and pop together when full is legal.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t      mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is only consumed while the count is nonzero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, buffers fetched words, delivers them to decode.
// Optional build macro FETCH_HALT_EN stops fetching on an all-zero word.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  FETCH_pc,
  input  logic [INSTR_W-1:0] FETCH_instr,
  fetch_if.master            out_bus,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted
);

  logic [ADDR_W-1:0] pc_q;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push;
  logic              room;
  logic              fetch_ok;
  logic              unused_low_bits;

  assign unused_low_bits = ^redirect_pc[1:0];

  // A redirect hides the head so nothing stale is consumed in the flush cycle.
  assign out_bus.out_valid = !fifo_empty && !redirect_valid;
  assign out_bus.out_pc    = fifo_empty ? '0 : head.pc;
  assign out_bus.out_instr = fifo_empty ? '0 : head.instr;

  assign pop        = out_bus.out_valid && out_bus.out_ready;
  assign room       = !fifo_full || pop;
  assign push       = room && fetch_ok && !redirect_valid;
  assign push_entry = '{pc: pc_q, instr: FETCH_instr};
  assign FETCH_pc   = pc_q;

`ifdef FETCH_HALT_EN
  logic halted_q;

  // A zero word marks the end of the program: park the PC on it and stop.
  assign fetch_ok = !halted_q && (FETCH_instr != '0);
  assign halted   = halted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else if (redirect_valid) begin
      halted_q <= 1'b0;
    end else if (!halted_q && (FETCH_instr == '0)) begin
      halted_q <= 1'b1;
    end
  end
`else
  assign fetch_ok = 1'b1;
  assign halted   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (push) begin
      pc_q <= pc_q + PC_STEP;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: ROM model, expected-PC scoreboard, directed timing checks.
// Build with FETCH_HALT_EN defined to exercise the halt-on-zero behaviour.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        halted;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  fetch_if bus ();

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- instruction memory model ----------------
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h2010000F;
      32'd4:   return 32'h20110014;
      32'd8:   return 32'h20120024;
      32'd12:  return 32'h02329820;
      32'd76:  return 32'h112AFFFF;
      default: begin
        if (a < 32'd80)         return 32'h24000000 | a;
        else if (a < 32'h1000)  return 32'h0;
        else                    return 32'hA5000000 ^ a;
      end
    endcase
  endfunction

  assign fetch_instr = rom(fetch_pc);

  fetch_ctrl #(
    .RESET_PC   (32'd0),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .FETCH_pc       (fetch_pc),
    .FETCH_instr    (fetch_instr),
    .out_bus        (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
    bus.out_ready  = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  // Scoreboard side: any handshake about to happen must match the next expected PC.
  task automatic tick();
    logic [31:0] p;
    if (bus.out_valid && bus.out_ready) begin
      check("sb_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        p = exp_q.pop_front();
        check("sb_pc", bus.out_pc, p);
        check("sb_instr", bus.out_instr, rom(p));
      end
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_pc", bus.out_pc, 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fetch_pc", fetch_pc, 32'd0);

    // streaming with decode always ready
    rst_n = 1'b1;
    drive(1, 0, 0);
    check("rel_valid", 32'(bus.out_valid), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0);
      check("stream_valid", 32'(bus.out_valid), 32'd1);
      tick();
    end
    drive(0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);

    // decode stalled for 5 cycles after reset
    rst_n = 1'b1;
    drive(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_out_pc", bus.out_pc, 32'd0);
      check("stall_out_instr", bus.out_instr, 32'h2010000F);
    end
    check("stall_fetch_pc", fetch_pc, 32'd8);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0);
      tick();
    end
    drive(0, 0, 0);
    check("full_fetch_pc", fetch_pc, 32'd24);

    // redirect to 76 while full
    drive(1, 1, 32'd76);
    check("redir_mask", 32'(bus.out_valid), 32'd0);
    tick();
    drive(1, 0, 0);
    check("redir_bubble", 32'(bus.out_valid), 32'd0);
    check("redir_fetch_pc", fetch_pc, 32'd76);
    exp_q.push_back(32'd76);
    tick();
    drive(1, 0, 0);
    check("redir_valid", 32'(bus.out_valid), 32'd1);
    check("redir_out_pc", bus.out_pc, 32'd76);
    check("redir_out_instr", bus.out_instr, 32'h112AFFFF);
    tick();
    drive(0, 0, 0);

    // run into the zero word at address 80
    drive(1, 1, 32'd72);
    tick();
    exp_q.push_back(32'd72);
    exp_q.push_back(32'd76);
`ifdef FETCH_HALT_EN
    repeat (3) begin
      drive(1, 0, 0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0);
      check("halt_valid", 32'(bus.out_valid), 32'd0);
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_fetch_pc", fetch_pc, 32'd80);
      tick();
    end
    drive(1, 1, 32'd0);
    tick();
    drive(1, 0, 0);
    check("unhalt_flag", 32'(halted), 32'd0);
    check("unhalt_fetch_pc", fetch_pc, 32'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    tick();
    repeat (2) begin
      drive(1, 0, 0);
      tick();
    end
`else
    exp_q.push_back(32'd80);
    repeat (4) begin
      drive(1, 0, 0);
      tick();
    end
    check("nohalt_flag", 32'(halted), 32'd0);
`endif
    drive(0, 0, 0);

    // PC wrap and misaligned redirect target
    drive(0, 1, 32'hFFFFFFFC);
    tick();
    drive(0, 0, 0);
    check("wrap_fetch_pc0", fetch_pc, 32'hFFFFFFFC);
    tick();
    check("wrap_fetch_pc1", fetch_pc, 32'h0);
    check("wrap_out_pc", bus.out_pc, 32'hFFFFFFFC);
    check("wrap_out_instr", bus.out_instr, rom(32'hFFFFFFFC));
    drive(0, 1, 32'h0000000D);
    tick();
    drive(0, 0, 0);
    check("align_fetch_pc", fetch_pc, 32'h0000000C);
    tick();
    tick();
    check("fill_fetch_pc", fetch_pc, 32'h14);
    check("fill_out_pc", bus.out_pc, 32'h0000000C);
    tick();
    check("fill_hold_pc", fetch_pc, 32'h14);

    // asynchronous reset with two buffered entries
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_fetch_pc", fetch_pc, 32'd0);
    check("mid_rst_out_pc", bus.out_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    tick();
    repeat (2) begin
      drive(1, 0, 0);
      tick();
    end
    drive(0, 0, 0);

    // final report
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that owns the program counter driving the instruction memory and delivers fetched instructions to decode through a valid/ready handshake. It buffers fetched words in a small FIFO so decode stalls do not lose or re-fetch instructions. It accepts branch/jump redirects from the execute stage. It sits between the combinational instruction ROM (PC in, instruction out, same cycle) and the decode stage.

## Interface
- RESET_PC, 32'd0, PC loaded on reset
- FIFO_DEPTH, 2, fetch buffer entries (>=2)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- FETCH_pc  out  32  address to instruction memory
- FETCH_instr  in  32  instruction memory data for FETCH_pc (combinational, same cycle)
- out_valid  out  1  out_instr/out_pc hold a valid instruction
- out_ready  in  1  decode accepts the head entry
- out_instr  out  32  head instruction
- out_pc  out  32  address of head instruction
- redirect_valid  in  1  one-cycle branch/jump taken pulse
- redirect_pc  in  32  redirect target
- halted  out  1  fetch stopped on zero word (tied 0 without FETCH_HALT_EN)

## Operation
- Reset: FETCH_pc=RESET_PC, FIFO empty, out_valid=0, out_instr=0, out_pc=0, halted=0.
- Each cycle, push {FETCH_pc, FETCH_instr} and advance FETCH_pc by 4 when FIFO has room. Room means count<FIFO_DEPTH, or count==FIFO_DEPTH with a pop in the same cycle.
- Pop occurs when out_valid && out_ready. Output comes from the registered FIFO head; there is no memory-to-output bypass.
- Full with no pop: no push, FETCH_pc holds.
- Redirect has priority over everything:
  - out_valid is masked to 0 in the redirect cycle, so no pop occurs.
  - FIFO is flushed at the edge.
  - FETCH_pc <= {redirect_pc[31:2], 2'b00}; misaligned low bits are dropped.
  - halted is cleared.
- PC arithmetic is 32-bit modulo: 32'hFFFFFFFC+4 -> 32'h0.
- Reset asserted mid-operation immediately returns all state to reset values, including discarding FIFO contents.

## Timing
- First instruction: out_valid=1 in the first cycle after the first clock edge following rst_n release; out_pc=RESET_PC.
- Steady state: one instruction per cycle with out_ready held high.
- Redirect at cycle N:
  - N+1: FETCH_pc=target.
  - N+2: out_valid=1, out_pc=target.
  - Two-cycle redirect bubble.
- out_instr and out_pc are stable while out_valid=1 and out_ready=0.

## Configuration
- FETCH_HALT_EN defined:
  - A fetched word equal to 32'h0 (instruction memory default beyond program end) is not pushed.
  - halted<=1 and FETCH_pc holds at that address.
  - Entries already buffered still drain normally.
  - Only redirect or reset clears halted.
- FETCH_HALT_EN undefined:
  - 32'h0 is fetched and delivered like any other instruction.
  - halted is constant 0.

## Structure
- Package fetch_pkg:
  - INSTR_W=32, ADDR_W=32, default RESET_PC.
  - fetch_entry_t struct {pc, instr}.
  - PC_STEP=4.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t.
  - Parameterised depth, count width $clog2(FIFO_DEPTH+1).
  - Ports: push/pop/flush, full/empty.
  - Simultaneous push and pop when full is legal.
- fetch_ctrl holds the PC register, room/redirect logic and the halt flag.

## Test plan
- Reset release, out_ready=1 -> out_pc 0,4,8,12 on consecutive cycles with out_instr 32'h2010000F, 32'h20110014, 32'h20120024, 32'h02329820.
- out_ready=0 for 5 cycles after reset:
  - FIFO fills at 2 entries; FETCH_pc stalls at 8.
  - out_pc/out_instr hold at 0/32'h2010000F.
  - Release -> pcs 0,4,8,12 in order, no duplicates or gaps.
- Redirect to 76 while FIFO full:
  - out_valid=0 for two cycles.
  - Then out_pc=76, out_instr=32'h112AFFFF; stale entries never appear.
- FETCH_HALT_EN, redirect to 72:
  - Delivers pcs 72,76; address 80 returns 0, so halted=1 and FETCH_pc holds 80.
  - Redirect to 0 clears halted and resumes at pc 0.
- Redirect to 32'hFFFFFFFC -> next FETCH_pc 32'h0 (wrap). Redirect to 32'h0000000D -> FETCH_pc 32'h0000000C.
- rst_n pulsed low mid-stream with FIFO holding 2 entries -> out_valid=0 immediately, FETCH_pc=RESET_PC, restart from pc 0.
